// File: rtl/inst_seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states, widths.
package inst_seq_pkg;

  localparam int unsigned INST_W_DEF = 10;

  // Opcode field is inst[0:1] (bit 0 is the MSB).
  localparam logic [1:0] OP_WR_IMM = 2'b00;
  localparam logic [1:0] OP_WR_REG = 2'b01;
  localparam logic [1:0] OP_RD_REG = 2'b10;  // mem->reg, issued for two cycles
  localparam logic [1:0] OP_DISP   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/inst_seq_prog_buf.sv
// Program buffer: synchronous write, asynchronous read, no reset on contents.
module prog_buf
  import inst_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned INST_W = INST_W_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [0:INST_W-1] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [0:INST_W-1] rdata
);

  logic [0:INST_W-1] mem_q [DEPTH];

  // Write port: one entry per load strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: combinational so inst follows pc in the same cycle.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/inst_seq.sv
// Instruction sequencer: buffers a short program and replays it to a
// downstream memory/register unit, stretching mem->reg reads to two cycles.
module inst_seq
  import inst_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned INST_W = INST_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [0:INST_W-1]        inst_in,
  input  logic                     load,
  input  logic                     start,
  input  logic                     clear,
  output logic [0:INST_W-1]        inst,
  output logic                     enable,
  output logic                     busy,
  output logic                     done,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_e            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              buf_we;
  logic [0:INST_W-1] rd_data;
  logic [1:0]        opcode;
  logic              at_last;
  logic              full_int;

  prog_buf #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) u_prog_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (count_q[AW-1:0]),
    .wdata (inst_in),
    .raddr (pc_q),
    .rdata (rd_data)
  );

  // Status decode shared by next-state logic and outputs.
  always_comb begin
    opcode   = rd_data[0:1];
    at_last  = ({1'b0, pc_q} == (count_q - CW'(1)));
    full_int = (count_q == CW'(DEPTH));
  end

  // State, pc and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: clear beats load, load beats start.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    buf_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (load) begin
          if (!full_int) begin
            buf_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end else if (start && (count_q != '0)) begin
          pc_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (clear) begin
          state_d = S_IDLE;
        end else if (opcode == OP_RD_REG) begin
          state_d = S_HOLD;
        end else if (at_last) begin
          state_d = S_DONE;
        end else begin
          pc_d = pc_q + AW'(1);
        end
      end
      S_HOLD: begin
        if (clear) begin
          state_d = S_IDLE;
        end else if (at_last) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (clear) begin
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state so reset drops enable immediately.
  // In DONE pc still points at the last entry, so inst keeps the last issue.
  always_comb begin
    enable = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    inst   = '0;
    case (state_q)
      S_RUN, S_HOLD: begin
        enable = 1'b1;
        busy   = 1'b1;
        inst   = rd_data;
      end
      S_DONE: begin
        done = 1'b1;
        inst = rd_data;
      end
      default: begin
        inst = '0;
      end
    endcase
    full  = full_int;
    count = count_q;
  end

endmodule

// File: tb/tb_inst_seq.sv
// Self-checking bench for inst_seq (DEPTH 8, INST_W 10).
module tb_inst_seq;

  typedef struct {
    logic       en;
    logic [0:9] inst;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
    logic       full;
  } exp_t;

  typedef struct {
    logic       ld;
    logic       st;
    logic       cl;
    logic [0:9] din;
    exp_t       e;
    string      name;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [0:9] inst_in;
  logic       load;
  logic       start;
  logic       clear;
  logic [0:9] inst;
  logic       enable;
  logic       busy;
  logic       done;
  logic       full;
  logic [3:0] count;

  int unsigned n_tests;
  int unsigned n_fail;
  exp_t        sb [$];
  vec_t        tbl [$];

  inst_seq #(
    .DEPTH  (8),
    .INST_W (10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inst_in (inst_in),
    .load    (load),
    .start   (start),
    .clear   (clear),
    .inst    (inst),
    .enable  (enable),
    .busy    (busy),
    .done    (done),
    .full    (full),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(logic en, logic [0:9] i, logic b, logic d,
                              logic [3:0] c, logic f);
    exp_t e;
    e.en = en; e.inst = i; e.busy = b; e.done = d; e.cnt = c; e.full = f;
    return e;
  endfunction

  function automatic logic [0:9] p_inst(int unsigned k);
    logic [7:0] lo;
    lo = 8'(k * 3 + 1);
    return {2'b01, lo};
  endfunction

  function automatic logic [0:9] e_inst(int unsigned k);
    logic [7:0] lo;
    lo = 8'(8'hA0 + k);
    return {2'b00, lo};
  endfunction

  task automatic check(input exp_t e, input string name);
    n_tests++;
    if (enable !== e.en || inst !== e.inst || busy !== e.busy ||
        done !== e.done || count !== e.cnt || full !== e.full) begin
      n_fail++;
      $display("FAIL %s: got en=%b inst=%b busy=%b done=%b count=%0d full=%b, required en=%b inst=%b busy=%b done=%b count=%0d full=%b",
               name, enable, inst, busy, done, count, full,
               e.en, e.inst, e.busy, e.done, e.cnt, e.full);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input logic ld, input logic st, input logic cl,
                      input logic [0:9] din, input exp_t e, input string name);
    exp_t got_e;
    @(negedge clk);
    load = ld; start = st; clear = cl; inst_in = din;
    sb.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; clear = 1'b0;
    got_e = sb.pop_front();
    check(got_e, name);
  endtask

  localparam logic [0:9] A = 10'b0000110101;
  localparam logic [0:9] B = 10'b0100100010;
  localparam logic [0:9] C = 10'b1100010000;
  localparam logic [0:9] D = 10'b1000110000;
  localparam logic [0:9] F = 10'b1011110000;
  localparam logic [0:9] Z = 10'b0;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    load    = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    inst_in = '0;

    // Three-instruction program, idle/DONE corner cases, and a single mem->reg read.
    tbl.push_back('{1'b1, 1'b0, 1'b0, A, mk(0, Z, 0, 0, 1, 0), "s1_ld0"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, B, mk(0, Z, 0, 0, 2, 0), "s1_ld1"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, C, mk(0, Z, 0, 0, 3, 0), "s1_ld2"});
    tbl.push_back('{1'b0, 1'b1, 1'b0, Z, mk(1, A, 1, 0, 3, 0), "s1_run0"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z, mk(1, B, 1, 0, 3, 0), "s1_run1"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z, mk(1, C, 1, 0, 3, 0), "s1_run2"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z, mk(0, C, 0, 1, 3, 0), "s1_done"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, D, mk(0, C, 0, 1, 3, 0), "s1_ld_in_done"});
    tbl.push_back('{1'b0, 1'b1, 1'b0, Z, mk(0, C, 0, 1, 3, 0), "s1_st_in_done"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, Z, mk(0, Z, 0, 0, 0, 0), "s1_clr_done"});
    tbl.push_back('{1'b0, 1'b1, 1'b0, Z, mk(0, Z, 0, 0, 0, 0), "st_cnt0"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, A, mk(0, Z, 0, 0, 0, 0), "clr_over_ld"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, D, mk(0, Z, 0, 0, 1, 0), "s2_ld"});
    tbl.push_back('{1'b0, 1'b1, 1'b0, Z, mk(1, D, 1, 0, 1, 0), "s2_run"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z, mk(1, D, 1, 0, 1, 0), "s2_hold"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, Z, mk(0, D, 0, 1, 1, 0), "s2_done"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, Z, mk(0, Z, 0, 0, 0, 0), "s2_clr"});

    #3;
    check(mk(0, Z, 0, 0, 0, 0), "reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].st, tbl[i].cl, tbl[i].din, tbl[i].e, tbl[i].name);
    end

    // Fill to DEPTH, one extra load must be dropped and never issued.
    for (int unsigned k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, p_inst(k), mk(0, Z, 0, 0, 4'(k + 1), (k == 7)), "s3_ld");
    end
    step(1'b1, 1'b0, 1'b0, p_inst(8), mk(0, Z, 0, 0, 8, 1), "s3_ld_full");
    step(1'b0, 1'b1, 1'b0, Z, mk(1, p_inst(0), 1, 0, 8, 1), "s3_run0");
    for (int unsigned k = 1; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0, Z, mk(1, p_inst(k), 1, 0, 8, 1), "s3_run");
    end
    step(1'b0, 1'b0, 1'b0, Z, mk(0, p_inst(7), 0, 1, 8, 1), "s3_done");
    step(1'b0, 1'b0, 1'b1, Z, mk(0, Z, 0, 0, 0, 0), "s3_clr");

    // Abort in the second run cycle, then replay from the first entry.
    for (int unsigned k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, e_inst(k), mk(0, Z, 0, 0, 4'(k + 1), 0), "s4_ld");
    end
    step(1'b0, 1'b1, 1'b0, Z, mk(1, e_inst(0), 1, 0, 4, 0), "s4_run0");
    step(1'b0, 1'b0, 1'b0, Z, mk(1, e_inst(1), 1, 0, 4, 0), "s4_run1");
    step(1'b0, 1'b0, 1'b1, Z, mk(0, Z, 0, 0, 4, 0), "s4_abort");
    step(1'b0, 1'b1, 1'b0, Z, mk(1, e_inst(0), 1, 0, 4, 0), "s4_replay0");
    step(1'b1, 1'b1, 1'b0, A, mk(1, e_inst(1), 1, 0, 4, 0), "s4_ld_in_run");
    step(1'b0, 1'b0, 1'b0, Z, mk(1, e_inst(2), 1, 0, 4, 0), "s4_replay2");
    step(1'b0, 1'b0, 1'b0, Z, mk(1, e_inst(3), 1, 0, 4, 0), "s4_replay3");
    step(1'b0, 1'b0, 1'b0, Z, mk(0, e_inst(3), 0, 1, 4, 0), "s4_done");
    step(1'b0, 1'b0, 1'b1, Z, mk(0, Z, 0, 0, 0, 0), "s4_clr");

    // Load and start together: load wins; then clear beats both.
    step(1'b1, 1'b0, 1'b0, A, mk(0, Z, 0, 0, 1, 0), "s5_ld0");
    step(1'b1, 1'b0, 1'b0, B, mk(0, Z, 0, 0, 2, 0), "s5_ld1");
    step(1'b1, 1'b1, 1'b0, C, mk(0, Z, 0, 0, 3, 0), "s5_ld_st");
    step(1'b1, 1'b1, 1'b1, D, mk(0, Z, 0, 0, 0, 0), "s5_clr_all");

    // Asynchronous reset while in HOLD.
    step(1'b1, 1'b0, 1'b0, F, mk(0, Z, 0, 0, 1, 0), "s6_ld");
    step(1'b0, 1'b1, 1'b0, Z, mk(1, F, 1, 0, 1, 0), "s6_run");
    step(1'b0, 1'b0, 1'b0, Z, mk(1, F, 1, 0, 1, 0), "s6_hold");
    #1;
    rst_n = 1'b0;
    #1;
    check(mk(0, Z, 0, 0, 0, 0), "s6_async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, Z, mk(0, Z, 0, 0, 0, 0), "s6_st_after_rst");
    step(1'b0, 1'b0, 1'b0, Z, mk(0, Z, 0, 0, 0, 0), "s6_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
